// File: rtl/voltmeter_pkg.sv
// Shared definitions for the XADC voltmeter scan path.
// Contents:
//   N_CH_DEF      default number of scanned channels (VP/VN plus VAUX0..VAUX11)
//   state_e       scan sequencer state encoding
//   addr_table()  channel index -> XADC DRP status register address
package voltmeter_pkg;

    localparam int N_CH_DEF = 13;

    // Channel indices at or above this value have no DRP address.
    localparam logic [3:0] ADDR_CH_LIMIT = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // ch0 is the dedicated VP/VN input (7'h03); ch1..ch12 map onto the
    // contiguous VAUX0..VAUX11 status registers starting at 7'h10.
    function automatic logic [6:0] addr_table(input logic [3:0] ch);
        logic [6:0] addr;
        if (ch == 4'd0) begin
            addr = 7'h03;
        end else if (ch < ADDR_CH_LIMIT) begin
            addr = 7'h0F + {3'b000, ch};
        end else begin
            addr = 7'h00;
        end
        return addr;
    endfunction

endpackage

// File: rtl/channel_bank.sv
// Register file holding the latest 12-bit conversion result per channel.
// Ports:
//   clk, rst          clock and synchronous active-high reset (clears every entry)
//   wr_en             write strobe
//   wr_addr, wr_data  write channel index and 12-bit result
//   rd_addr           read channel index
//   rd_data           registered read data; 0 for indices outside the bank
// A read and a write to the same entry in one cycle return the old contents.
module channel_bank
    import voltmeter_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int DW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [3:0]    rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [3:0] DEPTH = 4'(N_CH);

    logic [DW-1:0] mem_r [N_CH];
    logic [DW-1:0] rd_data_r;

    // Storage array: cleared on reset, single synchronous write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (wr_en && (wr_addr < DEPTH)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; sees the array before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DW{1'b0}};
        end else if (rd_addr < DEPTH) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= {DW{1'b0}};
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/xadc_scan_sequencer.sv
// Walks the XADC voltmeter channels over the DRP, stores every 12-bit
// result in a channel bank and repeats after an idle gap.
// Ports:
//   clk, rst                 100 MHz clock, synchronous active-high reset
//   enable                   level; passes start and repeat while high
//   drp_den/dwe/daddr        DRP read request (dwe held at 0)
//   drp_do, drp_drdy         DRP read data and data-ready pulse
//   rd_ch, rd_data           registered random-access read of the bank
//   scan_done                one-cycle pulse in the STORE cycle of the last channel
//   timeout_flags            bit k set when the latest read of channel k timed out
//   busy                     high whenever the sequencer is not IDLE
module xadc_scan_sequencer
    import voltmeter_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int TIMEOUT  = 255,
    parameter int SCAN_GAP = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    output logic            drp_den,
    output logic            drp_dwe,
    output logic [6:0]      drp_daddr,
    input  logic [15:0]     drp_do,
    input  logic            drp_drdy,
    input  logic [3:0]      rd_ch,
    output logic [11:0]     rd_data,
    output logic            scan_done,
    output logic [N_CH-1:0] timeout_flags,
    output logic            busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(SCAN_GAP + 1);

    // WAIT lasts at most TIMEOUT cycles (counter 0..TIMEOUT-1).
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    // GAP holds for SCAN_GAP+1 cycles so a pass repeats every
    // N_CH*(2+d) + SCAN_GAP + 1 cycles.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SCAN_GAP);
    localparam logic [3:0]        CH_LAST   = 4'(N_CH - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [3:0]        ch_r;
    logic [3:0]        ch_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              ok_r;
    logic [11:0]       data_r;
    logic [N_CH-1:0]   flags_r;
    logic              den_r;
    logic [6:0]        daddr_r;
    logic              scan_done_r;
    logic              busy_r;
    logic              bank_we_s;
    logic              unused_s;

    // Next-state and next-channel decode.
    always_comb begin
        state_next_s = state_r;
        ch_next_s    = ch_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_REQ;
                    ch_next_s    = 4'd0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                // drdy is checked first so a reply on the last WAIT cycle still counts.
                if (drp_drdy) begin
                    state_next_s = ST_STORE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = ST_STORE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_STORE: begin
                if (ch_r == CH_LAST) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_REQ;
                    ch_next_s    = ch_r + 4'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    if (enable) begin
                        state_next_s = ST_REQ;
                        ch_next_s    = 4'd0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ch_next_s    = 4'd0;
            end
        endcase
    end

    // State and channel index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ch_r    <= 4'd0;
        end else begin
            state_r <= state_next_s;
            ch_r    <= ch_next_s;
        end
    end

    // WAIT timeout counter and GAP counter; each is zero outside its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
        end else begin
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
        end
    end

    // Capture the read outcome as WAIT exits; STORE acts on it next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ok_r   <= 1'b0;
            data_r <= 12'h000;
        end else if ((state_r == ST_WAIT) && (state_next_s == ST_STORE)) begin
            ok_r <= drp_drdy;
            if (drp_drdy) begin
                data_r <= drp_do[15:4];
            end
        end
    end

    // Per-channel timeout flags, updated in STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= {N_CH{1'b0}};
        end else if (state_r == ST_STORE) begin
            flags_r[ch_r] <= ~ok_r;
        end
    end

    // Registered DRP request and status outputs, derived from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            den_r       <= 1'b0;
            daddr_r     <= 7'h00;
            scan_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            den_r       <= (state_next_s == ST_REQ);
            if (state_next_s == ST_REQ) begin
                daddr_r <= addr_table(ch_next_s);
            end
            scan_done_r <= (state_next_s == ST_STORE) && (ch_r == CH_LAST);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // A timed-out read leaves the bank entry untouched.
    assign bank_we_s = (state_r == ST_STORE) && ok_r;

    channel_bank #(
        .N_CH (N_CH),
        .DW   (12)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we_s),
        .wr_addr (ch_r),
        .wr_data (data_r),
        .rd_addr (rd_ch),
        .rd_data (rd_data)
    );

    // The four LSBs of the DRP word are below the 12-bit result.
    assign unused_s = ^drp_do[3:0];

    assign drp_den       = den_r;
    assign drp_dwe       = 1'b0;
    assign drp_daddr     = daddr_r;
    assign scan_done     = scan_done_r;
    assign timeout_flags = flags_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
module tb_xadc_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_do = 16'h0000;
    logic        drp_drdy = 1'b0;
    logic [3:0]  rd_ch;
    logic [11:0] rd_data;
    logic        scan_done;
    logic [12:0] timeout_flags;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // DRP responder model
    logic [15:0] reply_mem [128];
    logic [127:0] mute = 128'd0;
    int          lat = 3;
    int          pend_cnt = 0;
    logic [6:0]  pend_addr = 7'h00;
    logic [6:0]  addr_q [$];

    xadc_scan_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .drp_den       (drp_den),
        .drp_dwe       (drp_dwe),
        .drp_daddr     (drp_daddr),
        .drp_do        (drp_do),
        .drp_drdy      (drp_drdy),
        .rd_ch         (rd_ch),
        .rd_data       (rd_data),
        .scan_done     (scan_done),
        .timeout_flags (timeout_flags),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Replies lat cycles after the request cycle; drdy is set up at the
    // falling edge so the DUT samples it at the following rising edge.
    always @(negedge clk) begin
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                drp_drdy = 1'b1;
                drp_do   = reply_mem[pend_addr];
            end else begin
                drp_drdy = 1'b0;
            end
        end else begin
            drp_drdy = 1'b0;
        end
        if (drp_den && !mute[drp_daddr]) begin
            pend_cnt  = lat;
            pend_addr = drp_daddr;
        end
    end

    // Log of every issued DRP address.
    always @(negedge clk) begin
        if (drp_den) addr_q.push_back(drp_daddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!scan_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done_seen", {31'd0, scan_done}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_den(input logic [6:0] addr);
        int n;
        n = 0;
        @(negedge clk);
        while (!(drp_den && drp_daddr == addr) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("den_seen", {24'd0, drp_den, drp_daddr}, {24'd0, 1'b1, addr});
    endtask

    task automatic read_bank(input logic [3:0] ch, input logic [11:0] exp, input string tag);
        rd_ch = ch;
        @(negedge clk);
        chk(tag, {20'd0, rd_data}, {20'd0, exp});
    endtask

    initial begin
        int t1, t2, t3, t4, base, dens;
        logic [6:0] ea;
        for (int i = 0; i < 128; i++) reply_mem[i] = 16'hABC0;
        rst    = 1'b1;
        enable = 1'b0;
        rd_ch  = 4'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_den",   {31'd0, drp_den}, 32'd0);
        chk("rst_dwe",   {31'd0, drp_dwe}, 32'd0);
        chk("rst_done",  {31'd0, scan_done}, 32'd0);
        chk("rst_rd",    {20'd0, rd_data}, 32'd0);
        chk("rst_flags", {19'd0, timeout_flags}, 32'd0);

        // Normal scanning, d=3, every channel replies ABC0
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        base   = addr_q.size();
        enable = 1'b1;
        @(negedge clk);
        chk("start_busy",  {31'd0, busy}, 32'd1);
        chk("start_den",   {31'd0, drp_den}, 32'd1);
        chk("start_daddr", {25'd0, drp_daddr}, 32'h03);
        wait_done(t1);
        chk("pass1_ndens", addr_q.size() - base, 32'd13);
        for (int i = 0; i < 13; i++) begin
            ea = (i == 0) ? 7'h03 : 7'(7'h10 + i - 1);
            chk("pass1_addr", {25'd0, addr_q[base + i]}, {25'd0, ea});
        end
        chk("pass1_flags", {19'd0, timeout_flags}, 32'd0);
        wait_done(t2);
        chk("period_ok", t2 - t1, 32'd1066);
        for (int i = 0; i < 13; i++) read_bank(4'(i), 12'hABC, "bank_abc");
        rd_ch = 4'd14;
        @(negedge clk);
        chk("rd_oob", {20'd0, rd_data}, 32'd0);

        // ch5 never answers
        mute[7'h14] = 1'b1;
        wait_done(t3);
        chk("period_tmo", t3 - t2, 32'd1318);
        chk("tmo_flags", {19'd0, timeout_flags}, 32'h0020);
        read_bank(4'd5, 12'hABC, "tmo_bank5_kept");

        // ch5 answers again with 1230
        mute[7'h14]      = 1'b0;
        reply_mem[7'h14] = 16'h1230;
        wait_done(t4);
        chk("period_rec", t4 - t3, 32'd1066);
        chk("rec_flags", {19'd0, timeout_flags}, 32'd0);
        read_bank(4'd5, 12'h123, "rec_bank5");
        read_bank(4'd4, 12'hABC, "rec_bank4");

        // Read-before-write on ch2: 111 then 555
        reply_mem[7'h11] = 16'h1110;
        wait_done(t1);
        read_bank(4'd2, 12'h111, "bank2_111");
        reply_mem[7'h11] = 16'h5550;
        rd_ch = 4'd2;
        wait_den(7'h11);
        repeat (5) @(negedge clk);
        chk("rbw_old", {20'd0, rd_data}, 32'h111);
        @(negedge clk);
        chk("rbw_new", {20'd0, rd_data}, 32'h555);
        rd_ch = 4'd14;
        @(negedge clk);
        chk("rd_oob2", {20'd0, rd_data}, 32'd0);

        // Drop enable while ch7 is in WAIT
        wait_den(7'h16);
        @(negedge clk);
        enable = 1'b0;
        base   = addr_q.size();
        wait_done(t1);
        chk("drop_ndens", addr_q.size() - base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            ea = 7'(7'h17 + i);
            chk("drop_addr", {25'd0, addr_q[base + i]}, {25'd0, ea});
        end
        dens = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (drp_den) dens++;
        end
        chk("drop_no_den", dens, 32'd0);
        chk("drop_idle",   {31'd0, busy}, 32'd0);

        // Reset during WAIT of ch9, with ch5 timing out earlier in the pass
        mute[7'h14] = 1'b1;
        rd_ch  = 4'd0;
        enable = 1'b1;
        wait_den(7'h18);
        chk("pre_rst_flags", {19'd0, timeout_flags}, 32'h0020);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("mrst_busy",  {31'd0, busy}, 32'd0);
        chk("mrst_den",   {31'd0, drp_den}, 32'd0);
        chk("mrst_rd",    {20'd0, rd_data}, 32'd0);
        chk("mrst_flags", {19'd0, timeout_flags}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("late_busy", {31'd0, busy}, 32'd0);
        chk("late_den",  {31'd0, drp_den}, 32'd0);
        for (int i = 0; i < 13; i++) read_bank(4'(i), 12'h000, "mrst_bank");
        chk("late_flags", {19'd0, timeout_flags}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
